// File: rtl/axis_packet_receiver.sv
// AXI-stream slave that buffers 8-bit beats in a FIFO and reports per-packet
// length, checksum and oversize error; a pull-style port drains the FIFO.
module axis_packet_receiver #(
  parameter int DEPTH   = 16,
  parameter int MAX_LEN = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tvaild,
  input  logic [7:0]                 tdata,
  input  logic                       tlast,
  output logic                       tready,
  input  logic                       rd_en,
  output logic [7:0]                 rd_data,
  output logic                       rd_valid,
  output logic                       fifo_empty,
  output logic                       fifo_full,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       pkt_done,
  output logic [7:0]                 pkt_len,
  output logic [7:0]                 pkt_sum,
  output logic                       pkt_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [7:0]  MAX_C   = 8'(MAX_LEN);

  typedef enum logic {IDLE, RECV} state_t;

  state_t          state, state_next;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     count, count_next;
  logic [7:0]      cnt, beat_num, sum_run;
  logic            err_run;
  logic            accept, store, pop;

  always_comb begin
    accept     = tvaild & tready;
    pop        = rd_en & (count != '0);
    // Beat number this beat would carry; restarts at 1 whenever a packet opens.
    beat_num   = (state == IDLE) ? 8'd1 : ((cnt == 8'hFF) ? 8'hFF : cnt + 8'd1);
    store      = accept & (beat_num <= MAX_C);
    count_next = count + (AW+1)'(store) - (AW+1)'(pop);
    state_next = state;
    case (state)
      IDLE: if (accept && !tlast) state_next = RECV;
      RECV: if (accept && tlast)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tready   <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      cnt      <= '0;
      sum_run  <= '0;
      err_run  <= 1'b0;
      pkt_done <= 1'b0;
      pkt_len  <= '0;
      pkt_sum  <= '0;
      pkt_err  <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      tready   <= (count_next < DEPTH_C);
      rd_valid <= pop;
      pkt_done <= accept & tlast;
      if (store) wptr <= wptr + 1'b1;
      if (pop) begin
        rd_data <= mem[rptr];
        rptr    <= rptr + 1'b1;
      end
      if (accept) begin
        cnt <= beat_num;
        if (tlast) begin
          pkt_len <= beat_num;
          pkt_sum <= store ? sum_run + tdata : sum_run;
          pkt_err <= err_run | ~store;
          sum_run <= '0;
          err_run <= 1'b0;
        end else begin
          if (store) sum_run <= sum_run + tdata;
          else       err_run <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem[wptr] <= tdata;
  end

  assign fifo_count = count;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);

endmodule

// File: tb/tb_axis_packet_receiver.sv
// Scoreboard bench for axis_packet_receiver (DEPTH=16, MAX_LEN=8).
module tb_axis_packet_receiver;

  localparam int DEPTH   = 16;
  localparam int MAX_LEN = 8;

  logic       clk = 1'b0;
  logic       reset, tvaild, tlast, rd_en;
  logic [7:0] tdata;
  logic       tready, rd_valid, fifo_empty, fifo_full, pkt_done, pkt_err;
  logic [7:0] rd_data, pkt_len, pkt_sum;
  logic [4:0] fifo_count;

  axis_packet_receiver #(.DEPTH(DEPTH), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset(reset), .tvaild(tvaild), .tdata(tdata), .tlast(tlast),
    .tready(tready), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count),
    .pkt_done(pkt_done), .pkt_len(pkt_len), .pkt_sum(pkt_sum), .pkt_err(pkt_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] len; logic [7:0] sum; logic err; } pkt_t;

  int   checks = 0;
  int   failures = 0;
  int   done_count = 0;
  logic [7:0] exp_q[$];
  pkt_t       pkt_q[$];
  bit         in_pkt = 0;
  int         mcnt = 0;
  logic [7:0] msum = '0;
  logic       merr = 1'b0;

  always @(negedge clk) if (pkt_done === 1'b1) done_count++;

  // Reference model of one accepted beat: queues stored bytes and packet results.
  task automatic model_beat(input logic [7:0] d, input logic l);
    if (!in_pkt) mcnt = 1; else if (mcnt < 255) mcnt++;
    if (mcnt <= MAX_LEN) begin exp_q.push_back(d); msum = msum + d; end
    else merr = 1'b1;
    if (l) begin
      pkt_q.push_back('{len: 8'(mcnt), sum: msum, err: merr});
      in_pkt = 0; msum = '0; merr = 1'b0;
    end else in_pkt = 1;
  endtask

  task automatic check_pkt(input string tag);
    pkt_t e;
    checks++;
    if (pkt_done !== 1'b1 || pkt_q.size() == 0) begin
      failures++;
      $display("FAIL %s pkt_done: got %b, expected 1 (queued=%0d)", tag, pkt_done, pkt_q.size());
    end else begin
      e = pkt_q.pop_front();
      checks++;
      if (pkt_len !== e.len || pkt_sum !== e.sum || pkt_err !== e.err) begin
        failures++;
        $display("FAIL %s pkt: got len=%0d sum=%0d err=%b, expected len=%0d sum=%0d err=%b",
                 tag, pkt_len, pkt_sum, pkt_err, e.len, e.sum, e.err);
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send(input logic [7:0] d, input logic l, input string tag);
    int k = 0;
    tvaild = 1'b1; tdata = d; tlast = l;
    while (tready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) begin
      checks++; failures++;
      $display("FAIL %s timeout: tready stayed %b, expected 1", tag, tready);
    end
    model_beat(d, l);
    @(negedge clk);
    tvaild = 1'b0; tlast = 1'b0;
    if (l) check_pkt(tag);
  endtask

  task automatic read_n(input int n, input string tag);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== e) begin
        failures++;
        $display("FAIL %s read%0d: got valid=%b data=%h, expected valid=1 data=%h",
                 tag, i, rd_valid, rd_data, e);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; tvaild = 1'b0; tlast = 1'b0; tdata = '0; rd_en = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (tready !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h00 || fifo_count !== 5'd0 ||
        fifo_empty !== 1'b1 || fifo_full !== 1'b0 || pkt_done !== 1'b0 ||
        pkt_len !== 8'd0 || pkt_sum !== 8'd0 || pkt_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: got tready=%b rv=%b rd=%h cnt=%0d e=%b f=%b done=%b len=%0d sum=%0d err=%b, expected 0 0 00 0 1 0 0 0 0 0",
               tready, rd_valid, rd_data, fifo_count, fifo_empty, fifo_full, pkt_done, pkt_len, pkt_sum, pkt_err);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (tready !== 1'b1) begin
      failures++; $display("FAIL reset_release tready: got %b, expected 1", tready);
    end
  endtask

  task automatic test_basic;
    for (int i = 1; i <= 4; i++) send(8'(i), i == 4, "basic");
    checks++;
    if (fifo_count !== 5'd4) begin
      failures++; $display("FAIL basic count: got %0d, expected 4", fifo_count);
    end
    read_n(4, "basic");
    checks++;
    if (fifo_empty !== 1'b1) begin
      failures++; $display("FAIL basic empty: got %b, expected 1", fifo_empty);
    end
  endtask

  task automatic test_backpressure;
    int acc = 0;
    logic [7:0] e;
    tvaild = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tdata = 8'h10 + 8'(acc);
      tlast = (acc % 4 == 3);
      if (tready === 1'b1) begin model_beat(tdata, tlast); acc++; end
      @(negedge clk);
      if (pkt_done === 1'b1) check_pkt("bp_pkt");
    end
    checks++;
    if (acc != 16 || tready !== 1'b0 || fifo_full !== 1'b1 || fifo_count !== 5'd16) begin
      failures++;
      $display("FAIL bp_full: got accepted=%0d tready=%b full=%b cnt=%0d, expected 16 0 1 16",
               acc, tready, fifo_full, fifo_count);
    end
    tdata = 8'h10 + 8'(acc); tlast = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (tready !== 1'b1 || rd_valid !== 1'b1 || rd_data !== e) begin
      failures++;
      $display("FAIL bp_release: got tready=%b valid=%b data=%h, expected 1 1 %h", tready, rd_valid, rd_data, e);
    end
    model_beat(tdata, tlast);
    @(negedge clk);
    tvaild = 1'b0; tlast = 1'b0;
    check_pkt("bp_17th");
    checks++;
    if (fifo_count !== 5'd16) begin
      failures++; $display("FAIL bp_refill count: got %0d, expected 16", fifo_count);
    end
    read_n(16, "bp_drain");
  endtask

  task automatic test_single_beat;
    send(8'hFF, 1'b1, "single");
    send(8'h01, 1'b0, "single2");
    send(8'h02, 1'b1, "single2");
    read_n(3, "single");
  endtask

  task automatic test_oversize;
    for (int i = 1; i <= 10; i++) send(8'(i), i == 10, "oversize");
    checks++;
    if (fifo_count !== 5'd8) begin
      failures++; $display("FAIL oversize count: got %0d, expected 8", fifo_count);
    end
    send(8'h03, 1'b0, "after_over");
    send(8'h04, 1'b1, "after_over");
    read_n(10, "oversize");
  endtask

  task automatic test_reset_mid;
    int d0;
    send(8'h07, 1'b0, "rst_mid");
    send(8'h08, 1'b0, "rst_mid");
    send(8'h09, 1'b0, "rst_mid");
    d0 = done_count;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (tready !== 1'b0 || fifo_count !== 5'd0) begin
      failures++; $display("FAIL rst_mid during: got tready=%b cnt=%0d, expected 0 0", tready, fifo_count);
    end
    reset = 1'b0;
    exp_q.delete(); in_pkt = 0; msum = '0; merr = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (done_count != d0) begin
      failures++; $display("FAIL rst_mid pkt_done: got %0d pulses, expected 0", done_count - d0);
    end
    send(8'h05, 1'b0, "rst_after");
    send(8'h06, 1'b1, "rst_after");
    read_n(2, "rst_after");
  endtask

  task automatic test_simultaneous;
    logic [7:0] e;
    for (int i = 0; i < 5; i++) send(8'h21 + 8'(i), i == 4, "simul_fill");
    tvaild = 1'b1; tdata = 8'h30; tlast = 1'b1; rd_en = 1'b1;
    e = exp_q.pop_front();
    model_beat(8'h30, 1'b1);
    @(negedge clk);
    tvaild = 1'b0; tlast = 1'b0; rd_en = 1'b0;
    checks++;
    if (fifo_count !== 5'd5 || rd_valid !== 1'b1 || rd_data !== e) begin
      failures++;
      $display("FAIL simul: got cnt=%0d valid=%b data=%h, expected 5 1 %h", fifo_count, rd_valid, rd_data, e);
    end
    check_pkt("simul");
    read_n(5, "simul_drain");
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_backpressure;
    test_single_beat;
    test_oversize;
    test_reset_mid;
    test_simultaneous;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
